// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver FSM state encoding, default frame geometry, parity modes.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_receiver_pkg;

  // Receiver FSM states (3-bit encoding)
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Default frame geometry: 16x oversampling, 8 data bits
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

  // Parity mode encoding, shared with the transmit path (value of parity_odd)
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer bringing the asynchronous rx line into the clk domain.
// Latency: 2 clk.
// Backpressure: none; both flops reset to 1 so the line reads idle out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: plain two-stage shift
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops, reset to line-idle level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive engine: deserializes one start/data/[parity]/stop frame on rx, LSB first.
// Latency: rx_valid one clk after the mid-stop-bit sample (plus 2 clk input synchronizer).
// Backpressure: none; rx_valid is a one-clk strobe and an unconsumed byte is overwritten.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  // Tick count at mid start bit, and at the end of a full bit period
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e                state_q, state_d;
  logic [TICK_W-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]     shift_q, shift_d;
  logic                     perr_q, perr_d;
  logic [DATA_BITS-1:0]     rx_data_q, rx_data_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     parity_error_q, parity_error_d;
  logic                     frame_error_q, frame_error_d;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Next-state, counters, shift register and result capture
  always_comb begin
    state_d        = state_q;
    tick_cnt_d     = tick_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    perr_d         = perr_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    parity_error_d = parity_error_q;
    frame_error_d  = frame_error_q;

    if (!en) begin
      // Drop any partial frame; delivered data and flags are kept
      state_d    = ST_IDLE;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (baud_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
            perr_d     = 1'b0;
          end
        end

        ST_START: begin
          if (tick_cnt_q == HALF_LAST) begin
            if (rx_s) begin
              // Line back high by mid start bit: glitch, not a frame
              state_d = ST_IDLE;
            end else begin
              state_d    = ST_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end

        ST_DATA: begin
          if (tick_cnt_q == FULL_LAST) begin
            // Shift in from the top: after DATA_BITS samples the first bit sits in bit 0
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
              state_d = parity_en ? ST_PARITY : ST_STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end

        ST_PARITY: begin
          if (tick_cnt_q == FULL_LAST) begin
            perr_d     = ((^shift_q) ^ rx_s) != parity_odd;
            tick_cnt_d = '0;
            state_d    = ST_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end

        ST_STOP: begin
          if (tick_cnt_q == FULL_LAST) begin
            rx_data_d      = shift_q;
            parity_error_d = parity_en & perr_q;
            frame_error_d  = ~rx_s;
            rx_valid_d     = 1'b1;
            // Leave at mid stop bit so the next start edge is caught early
            state_d        = ST_IDLE;
            tick_cnt_d     = '0;
            bit_cnt_d      = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end

        default: begin
          state_d    = ST_IDLE;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      tick_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      perr_q         <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      perr_q         <= perr_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign parity_error = parity_error_q;
  assign frame_error  = frame_error_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
